// File: rtl/sad_best_match.sv
// sad_best_match: accumulates per-row partial SADs into block SADs and reports
// the minimum-SAD candidate of each search over a valid/ready handshake.
module sad_best_match #(
  parameter int WIDTH      = 8,
  parameter int INPUTS     = 4,
  parameter int ROWS       = 4,
  parameter int CANDIDATES = 16,
  localparam int PW = WIDTH + $clog2(INPUTS),
  localparam int AW = PW + $clog2(ROWS),
  localparam int IW = (CANDIDATES > 1) ? $clog2(CANDIDATES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] partial_sad,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] best_sad,
  output logic [IW-1:0] best_idx
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, run_sad_q, run_sad_d, best_sad_q, best_sad_d;
  logic [IW-1:0] run_idx_q, run_idx_d, best_idx_q, best_idx_d, cand_q, cand_d;
  logic [RW-1:0] row_q, row_d;
  logic          run_vld_q, run_vld_d;
  logic [AW-1:0] sum;
  logic          better;
  assign sum       = acc_q + AW'(partial_sad);
  assign better    = !run_vld_q || (sum < run_sad_q);
  assign in_ready  = state_q == ACCUM;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == RESULT;
  assign best_sad  = best_sad_q;
  assign best_idx  = best_idx_q;
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    row_d      = row_q;
    cand_d     = cand_q;
    run_sad_d  = run_sad_q;
    run_idx_d  = run_idx_q;
    run_vld_d  = run_vld_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d     = '0;
        row_d     = '0;
        cand_d    = '0;
        run_vld_d = 1'b0;
        state_d   = ACCUM;
      end
      ACCUM: if (in_valid) begin
        if (row_q != RW'(ROWS - 1)) begin
          acc_d = sum;
          row_d = row_q + 1'b1;
        end else begin
          acc_d = '0;
          row_d = '0;
          if (better) begin
            run_sad_d = sum;
            run_idx_d = cand_q;
            run_vld_d = 1'b1;
          end
          // the published result is captured only here, so outputs hold steady through a whole search
          if (cand_q == IW'(CANDIDATES - 1)) begin
            best_sad_d = better ? sum : run_sad_q;
            best_idx_d = better ? cand_q : run_idx_q;
            state_d    = RESULT;
          end else begin
            cand_d = cand_q + 1'b1;
          end
        end
      end
      RESULT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      row_q      <= '0;
      cand_q     <= '0;
      run_sad_q  <= '0;
      run_idx_q  <= '0;
      run_vld_q  <= 1'b0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      row_q      <= row_d;
      cand_q     <= cand_d;
      run_sad_q  <= run_sad_d;
      run_idx_q  <= run_idx_d;
      run_vld_q  <= run_vld_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end
endmodule

// File: tb/tb_sad_best_match.sv
// tb_sad_best_match: scoreboard bench; the driver pushes model results, a negedge monitor
// pops and compares them on each output handshake.
module tb_sad_best_match;
  localparam int ROWS = 4, CANDS = 16, PW = 10, AW = 12, IW = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [PW-1:0] partial_sad = '0;
  logic in_ready, busy, out_valid;
  logic [AW-1:0] best_sad;
  logic [IW-1:0] best_idx;
  int tests = 0, fails = 0;
  int beats[CANDS][ROWS];
  int exp_sad, exp_idx;
  typedef struct {int sad; int idx;} res_t;
  res_t sb[$];

  sad_best_match #(.WIDTH(8), .INPUTS(4), .ROWS(ROWS), .CANDIDATES(CANDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .partial_sad(partial_sad), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .best_sad(best_sad), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model();
    int s;
    exp_sad = 0;
    exp_idx = 0;
    for (int c = 0; c < CANDS; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++) s += beats[c][r];
      if (c == 0 || s < exp_sad) begin
        exp_sad = s;
        exp_idx = c;
      end
    end
  endfunction

  task automatic feed(input int max_gap, input int ncand);
    for (int c = 0; c < ncand; c++)
      for (int r = 0; r < ROWS; r++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) tick();
        in_valid = 1'b1;
        partial_sad = PW'(beats[c][r]);
        check("in_ready_accum", int'(in_ready), 1);
        if (c == CANDS - 1 && r == ROWS - 1) check("out_valid_before_last", int'(out_valid), 0);
        tick();
      end
    in_valid = 1'b0;
    if (ncand == CANDS) check("out_valid_latency", int'(out_valid), 1);
  endtask

  task automatic search(input int max_gap, input bit iv_with_start);
    model();
    sb.push_back('{exp_sad, exp_idx});
    start = 1'b1;
    in_valid = iv_with_start;
    partial_sad = '0;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    feed(max_gap, CANDS);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
    check("returns_idle", int'(busy), 0);
  endtask

  function automatic void load_s1();
    for (int c = 0; c < CANDS; c++)
      for (int r = 0; r < ROWS; r++) beats[c][r] = 20 - c;
    beats[9] = '{1, 0, 2, 0};
  endfunction

  function automatic void load_rand(input int lo);
    for (int c = 0; c < CANDS; c++)
      for (int r = 0; r < ROWS; r++) beats[c][r] = $urandom_range(1020, lo);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sad %0d idx %0d expected none", best_sad, best_idx);
      end else begin
        res_t r;
        r = sb.pop_front();
        check("best_sad", int'(best_sad), r.sad);
        check("best_idx", int'(best_idx), r.idx);
      end
    end
  end

  initial begin
    #12;
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_best_sad", int'(best_sad), 0);
    check("reset_best_idx", int'(best_idx), 0);
    rst_n = 1'b1;
    tick();
    load_s1();
    search(0, 1'b0);
    check("s1_expect_sad", exp_sad, 3);
    wait_idle();
    for (int c = 0; c < CANDS; c++)
      for (int r = 0; r < ROWS; r++) beats[c][r] = 10;
    beats[3] = '{5, 0, 0, 0};
    beats[7] = '{1, 1, 1, 2};
    search(0, 1'b0);
    check("tie_expect_idx", exp_idx, 3);
    wait_idle();
    load_rand(0);
    out_ready = 1'b0;
    search(0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      start = 1'b0;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_busy", int'(busy), 1);
      check("hold_best_sad", int'(best_sad), exp_sad);
      check("hold_best_idx", int'(best_idx), exp_idx);
    end
    out_ready = 1'b1;
    tick();
    check("release_out_valid", int'(out_valid), 0);
    check("release_busy", int'(busy), 0);
    check("retain_best_sad", int'(best_sad), exp_sad);
    check("retain_best_idx", int'(best_idx), exp_idx);
    for (int c = 0; c < CANDS; c++)
      for (int r = 0; r < ROWS; r++) beats[c][r] = 1020;
    search(0, 1'b0);
    check("max_expect_sad", exp_sad, 4080);
    wait_idle();
    load_s1();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      partial_sad = '0;
      check("idle_in_ready", int'(in_ready), 0);
      tick();
      check("idle_busy", int'(busy), 0);
    end
    search(5, 1'b1);
    wait_idle();
    load_rand(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(2, 6);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_best_sad", int'(best_sad), 0);
    tick();
    rst_n = 1'b1;
    tick();
    load_rand(2);
    beats[12] = '{1, 2, 3, 1};
    search(1, 1'b0);
    check("abort_expect_idx", exp_idx, 12);
    wait_idle();
    for (int n = 0; n < 4; n++) begin
      load_rand(0);
      search(n, 1'b0);
      wait_idle();
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
